// File: rtl/jtframe_dump_pkg.sv
// jtframe_dump_pkg: shared types and constants for the SDRAM dump path.
package jtframe_dump_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DRAIN
   } fetch_st_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_STEP      = 2;
endpackage

// File: rtl/jtframe_dump_fifo.sv
// jtframe_dump_fifo: 2-entry 32-bit word buffer unpacked little-endian into bytes.
module jtframe_dump_fifo
   import jtframe_dump_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_flush,
   input  logic        i_push,
   input  logic [31:0] i_din,
   input  logic        i_en,
   input  logic        i_rd,
   output logic [7:0]  o_dout,
   output logic        o_vld,
   output logic        o_pop,
   output logic        o_full,
   output logic [1:0]  o_cnt
);
   logic [31:0] r_mem [2];
   logic        r_wp, r_rp;
   logic [1:0]  r_cnt, r_idx;
   logic [31:0] w_word;

   assign w_word = r_mem[r_rp];
   assign o_vld  = (r_cnt != 2'd0) && i_en;
   assign o_pop  = i_rd && o_vld && (r_idx == 2'(BYTES_PER_WORD - 1));
   assign o_dout = o_vld ? w_word[{r_idx, 3'b000} +: 8] : 8'h00;
   assign o_full = r_cnt == 2'd2;
   assign o_cnt  = r_cnt;

   always_ff @(posedge clk)
      if (i_push) r_mem[r_wp] <= i_din;

   // flush drops the surplus bytes of the final word when the transfer ends
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
         r_idx <= 2'd0;
      end else begin
         if (i_push) r_wp <= ~r_wp;
         if (o_pop) r_rp <= ~r_rp;
         if (i_rd && o_vld) r_idx <= r_idx + 2'd1;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, o_pop};
      end
   end
endmodule

// File: rtl/jtframe_sdram_dump.sv
// jtframe_sdram_dump: reads a byte range from SDRAM and serves it to the ioctl upload path.
module jtframe_sdram_dump
   import jtframe_dump_pkg::*;
#(
   parameter int AW   = 22,
   parameter int LENW = 24
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            dump_req,
   input  logic [AW-1:0]   dump_addr,
   input  logic [LENW-1:0] dump_bytes,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            sdram_req,
   output logic [AW-1:0]   sdram_addr,
   input  logic            sdram_ack,
   input  logic            data_rdy,
   input  logic [31:0]     data_read,
   input  logic            ioctl_rd,
   output logic [7:0]      ioctl_dout,
   output logic            ioctl_vld
);
   fetch_st_t       r_st, w_nxt;
   logic [AW-1:0]   r_addr;
   logic [LENW-2:0] r_fetch;
   logic [LENW-1:0] r_bytes;
   logic            r_busy, r_done, r_err;
   logic            w_start, w_push, w_take, w_last, w_room, w_pop, w_full, w_en;
   logic [1:0]      w_cnt;

   assign w_start = (r_st == ST_IDLE) && dump_req;
   assign w_push  = (r_st == ST_WAIT) && data_rdy;
   assign w_take  = ioctl_rd && ioctl_vld;
   assign w_last  = w_take && (r_bytes == LENW'(1));
   assign w_en    = r_bytes != '0;
   // room after this push, counting a pop in the same cycle
   assign w_room  = (w_cnt == 2'd0) || (w_cnt == 2'd1 && w_pop);

   jtframe_dump_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_last),
      .i_push  (w_push),
      .i_din   (data_read),
      .i_en    (w_en),
      .i_rd    (ioctl_rd),
      .o_dout  (ioctl_dout),
      .o_vld   (ioctl_vld),
      .o_pop   (w_pop),
      .o_full  (w_full),
      .o_cnt   (w_cnt)
   );

   always_ff @(posedge clk)
      if (rst) r_st <= ST_IDLE;
      else     r_st <= w_nxt;

   always_comb begin
      w_nxt = r_st;
      case (r_st)
         ST_IDLE:  if (dump_req && dump_bytes != '0) w_nxt = ST_REQ;
         ST_REQ:   if (sdram_ack) w_nxt = ST_WAIT;
         ST_WAIT:  if (data_rdy) w_nxt = r_fetch == (LENW-1)'(1) ? ST_DRAIN : w_room ? ST_REQ : ST_HOLD;
         ST_HOLD:  if (!w_full) w_nxt = ST_REQ;
         ST_DRAIN: if (w_last) w_nxt = ST_IDLE;
         default:  w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sdram_req  = r_st == ST_REQ;
      sdram_addr = r_addr;
      busy       = r_busy;
      done       = r_done;
      err        = r_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_fetch <= '0;
         r_bytes <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (ioctl_rd && !ioctl_vld) r_err <= 1'b1;
         if (w_start) begin
            r_addr  <= dump_addr;
            r_fetch <= {1'b0, dump_bytes[LENW-1:2]} + (LENW-1)'(|dump_bytes[1:0]);
            r_bytes <= dump_bytes;
            r_err   <= 1'b0;
            r_busy  <= dump_bytes != '0;
            r_done  <= dump_bytes == '0;
         end
         if (w_push) begin
            r_addr  <= r_addr + AW'(WORD_STEP);
            r_fetch <= r_fetch - (LENW-1)'(1);
         end
         if (w_take) r_bytes <= r_bytes - LENW'(1);
         if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_jtframe_sdram_dump.sv
// tb_jtframe_sdram_dump: randomized bench against a byte-list model of the SDRAM dump.
module tb_jtframe_sdram_dump;
   localparam int AW   = 22;
   localparam int LENW = 24;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            dump_req = 1'b0;
   logic [AW-1:0]   dump_addr = '0;
   logic [LENW-1:0] dump_bytes = '0;
   logic            busy, done, err, sdram_req, sdram_ack, data_rdy;
   logic [AW-1:0]   sdram_addr;
   logic [31:0]     data_read;
   logic            ioctl_rd = 1'b0;
   logic [7:0]      ioctl_dout;
   logic            ioctl_vld;

   logic        ack_a = 1'b0, rdy_a = 1'b0, ack_m = 1'b0, rdy_m = 1'b0;
   logic [31:0] dr_a = '0;
   bit          resp_en = 1'b1;
   logic [15:0] mem [4096];
   logic [AW-1:0] addr_q [$];
   int n_cmp = 0, n_bad = 0;

   assign sdram_ack = ack_a | ack_m;
   assign data_rdy  = rdy_a | rdy_m;
   assign data_read = rdy_m ? 32'hDEADBEEF : dr_a;

   jtframe_sdram_dump #(.AW(AW), .LENW(LENW)) dut (
      .clk        (clk),
      .rst        (rst),
      .dump_req   (dump_req),
      .dump_addr  (dump_addr),
      .dump_bytes (dump_bytes),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .data_rdy   (data_rdy),
      .data_read  (data_read),
      .ioctl_rd   (ioctl_rd),
      .ioctl_dout (ioctl_dout),
      .ioctl_vld  (ioctl_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SDRAM model: random ack and read latency, logs every accepted address
   initial begin
      int idx;
      forever begin
         @(negedge clk);
         if (resp_en && sdram_req && !rst) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            addr_q.push_back(sdram_addr);
            idx   = int'(sdram_addr[11:0]);
            ack_a = 1'b1;
            @(negedge clk);
            ack_a = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dr_a  = {mem[(idx + 1) % 4096], mem[idx]};
            rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0;
         end
      end
   end

   task automatic run(input logic [AW-1:0] a, input int n, input int rdpct, input bit errmode, input int stall);
      byte unsigned exp_q [$];
      logic [15:0]  w;
      int           got = 0, cyc = 0;
      bit           err_exp = 1'b0;
      for (int k = 0; k < n; k++) begin
         w = mem[(int'(a[11:0]) + k / 2) % 4096];
         exp_q.push_back(k % 2 == 1 ? w[15:8] : w[7:0]);
      end
      addr_q.delete();
      @(negedge clk);
      dump_addr  = a;
      dump_bytes = LENW'(n);
      dump_req   = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      check("err_clear", 32'(err), 0);
      check("busy_start", 32'(busy), 32'(n != 0));
      if (n == 0) begin
         check("zero_done", 32'(done), 1);
         check("zero_req", 32'(sdram_req), 0);
         @(negedge clk);
         check("zero_done_pulse", 32'(done), 0);
         check("zero_busy", 32'(busy), 0);
         check("zero_fetches", addr_q.size(), 0);
         return;
      end
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         check("hold_fetches", addr_q.size(), 2);
         check("hold_req", 32'(sdram_req), 0);
         check("hold_vld", 32'(ioctl_vld), 1);
      end
      while (got < n && cyc < 3000) begin
         check("busy_mid", 32'(busy), 1);
         ioctl_rd = 1'b0;
         if (ioctl_vld) begin
            if ($urandom_range(0, 99) < rdpct) begin
               check("byte", 32'(ioctl_dout), 32'(exp_q[got]));
               got++;
               ioctl_rd = 1'b1;
            end
         end else if (errmode && (cyc == 0 || $urandom_range(0, 1) == 1)) begin
            ioctl_rd = 1'b1;
            err_exp  = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      ioctl_rd = 1'b0;
      check("bytes_read", got, n);
      check("done", 32'(done), 1);
      check("busy_end", 32'(busy), 0);
      check("vld_end", 32'(ioctl_vld), 0);
      check("dout_end", 32'(ioctl_dout), 0);
      check("err", 32'(err), 32'(err_exp));
      check("nfetch", addr_q.size(), (n + 3) / 4);
      for (int i = 0; i < addr_q.size(); i++) check("fetch_addr", 32'(addr_q[i]), 32'(a) + 32'(2 * i));
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("vld_after", 32'(ioctl_vld), 0);
      check("err_sticky", 32'(err), 32'(err_exp));
   endtask

   initial begin
      int c;
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      mem[256] = 16'h2211;
      mem[257] = 16'h4433;
      mem[258] = 16'h6655;
      mem[259] = 16'h8877;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_req", 32'(sdram_req), 0);
      check("rst_addr", 32'(sdram_addr), 0);
      check("rst_vld", 32'(ioctl_vld), 0);
      check("rst_dout", 32'(ioctl_dout), 0);

      run(22'h100, 8, 100, 1'b0, 0);
      run(22'h100, 5, 100, 1'b0, 0);
      run(22'h100, 0, 100, 1'b0, 0);
      run(22'h200, 64, 100, 1'b0, 40);
      run(22'h300, 12, 60, 1'b1, 0);
      run(22'h100, 4, 100, 1'b0, 0);

      // reset while a read is in flight, then a stale data_rdy
      resp_en = 1'b0;
      @(negedge clk);
      dump_addr  = 22'h40;
      dump_bytes = LENW'(8);
      dump_req   = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      c = 0;
      while (!sdram_req && c < 20) begin
         c++;
         @(negedge clk);
      end
      check("mid_req_seen", 32'(sdram_req), 1);
      ack_m = 1'b1;
      @(negedge clk);
      ack_m = 1'b0;
      check("mid_req_fall", 32'(sdram_req), 0);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      rdy_m = 1'b1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_addr", 32'(sdram_addr), 0);
      @(negedge clk);
      rdy_m = 1'b0;
      @(negedge clk);
      check("stale_vld", 32'(ioctl_vld), 0);
      check("stale_dout", 32'(ioctl_dout), 0);
      check("stale_busy", 32'(busy), 0);
      check("stale_done", 32'(done), 0);
      check("stale_err", 32'(err), 0);
      check("stale_req", 32'(sdram_req), 0);
      resp_en = 1'b1;
      run(22'h40, 8, 100, 1'b0, 0);

      for (int t = 0; t < 12; t++)
         run(AW'($urandom_range(0, 2047) * 2), $urandom_range(1, 40), $urandom_range(20, 100),
             $urandom_range(0, 3) == 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
